instr_cache_refill: RTL

Direct-mapped, read-only instruction cache with an integrated line-refill state machine. It sits directly upstream of the fetch stage and serves word-addressed PCs, where the PC increments by 1 per instruction. It returns the instruction and a `hit` flag in the same cycle. On a miss it stalls the fetch stage and refills the whole line from a backing instruction memory over a request/valid handshake.

---
 rtl/instr_cache_refill_if.sv | 11 +
 rtl/instr_cache_refill.sv | 85 ++++++++
 2 files changed

// File: rtl/instr_cache_refill_if.sv
// instr_cache_refill_if: fetch-side and refill-memory signals of the instruction cache.
//   addr      fetch PC (word address)      data/hit  instruction and residency flag
//   mem_req   refill request               mem_addr  word address of the refill word
//   mem_rdata refill word                  mem_valid mem_rdata valid for current request
//   slave modport: cache side; master modport: fetch stage plus backing memory.
interface instr_cache_refill_if;
   logic [31:0] addr, data, mem_addr, mem_rdata;
   logic hit, mem_req, mem_valid;
   modport master(output addr, mem_rdata, mem_valid, input data, hit, mem_req, mem_addr);
   modport slave(input addr, mem_rdata, mem_valid, output data, hit, mem_req, mem_addr);
endinterface

// File: rtl/instr_cache_refill.sv
// instr_cache_refill: direct-mapped read-only instruction cache with line-refill FSM.
//   clk, rst         clock, synchronous active-high reset
//   bus (slave)      fetch addr/data/hit and refill mem_req/mem_addr/mem_rdata/mem_valid
//   hit_count, miss_count  statistics, present only when ICACHE_STATS_EN is defined
module instr_cache_refill #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input logic clk,
   input logic rst,
   instr_cache_refill_if.slave bus
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);
   localparam int OB = $clog2(WORDS);
   localparam int IB = $clog2(LINES);
   localparam int TW = 32 - OB - IB;
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_REFILL = 1'b1;
   logic [0:0] state_q, state_d;
   logic [OB-1:0] wcnt_q, wcnt_d;
   logic [31:0] fill_base_q, fill_base_d;
   logic [TW-1:0] fill_tag_q, fill_tag_d;
   logic [LINES-1:0] valid_q;
   logic [TW-1:0] tag_q [LINES];
   logic [31:0] line_q [LINES][WORDS];
   logic [OB-1:0] off;
   logic [IB-1:0] idx, fill_idx;
   logic [TW-1:0] tag;
   logic miss, accept, last;
   assign off = bus.addr[OB-1:0];
   assign idx = bus.addr[OB+IB-1:OB];
   assign tag = bus.addr[31:OB+IB];
   assign fill_idx = fill_base_q[OB+IB-1:OB];
   assign bus.hit = state_q == S_IDLE && valid_q[idx] && tag_q[idx] == tag;
   assign bus.data = bus.hit ? line_q[idx][off] : '0;
   assign bus.mem_req = state_q == S_REFILL;
   // fill_base is line aligned, so OR-ing in the word counter is the sum
   assign bus.mem_addr = bus.mem_req ? (fill_base_q | 32'(wcnt_q)) : '0;
   assign miss = state_q == S_IDLE && !bus.hit;
   assign accept = bus.mem_req && bus.mem_valid;
   assign last = wcnt_q == OB'(WORDS - 1);
   always_comb begin
      state_d = miss ? S_REFILL : (accept && last) ? S_IDLE : state_q;
      wcnt_d = miss ? '0 : accept ? wcnt_q + 1'b1 : wcnt_q;
      fill_base_d = miss ? {bus.addr[31:OB], {OB{1'b0}}} : fill_base_q;
      fill_tag_d = miss ? tag : fill_tag_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         wcnt_q <= '0;
         fill_base_q <= '0;
         fill_tag_q <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q <= wcnt_d;
         fill_base_q <= fill_base_d;
         fill_tag_q <= fill_tag_d;
         // evict at the miss edge; the line only becomes valid once fully written
         if (miss) valid_q[idx] <= 1'b0;
         else if (accept && last) valid_q[fill_idx] <= 1'b1;
      end
   end
   // storage needs no reset: it is qualified by valid_q; a word arriving with rst is dropped
   always_ff @(posedge clk) begin
      if (!rst && accept) line_q[fill_idx][wcnt_q] <= bus.mem_rdata;
      if (!rst && accept && last) tag_q[fill_idx] <= fill_tag_q;
   end
`ifdef ICACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count <= '0;
         miss_count <= '0;
      end else begin
         if (bus.hit) hit_count <= hit_count + 32'd1;
         if (miss) miss_count <= miss_count + 32'd1;
      end
   end
`endif
endmodule
